// File: rtl/taitosj_obj_pkg.sv
// rtl/taitosj_obj_pkg.sv - shared types and constants for the object pixel path
// Purpose: default geometry, fetch FSM state encoding, HN phase constants and
//          the bit-reverse helper used for horizontal flip.
// Ports:   none (package).
package taitosj_obj_pkg;

    localparam int GFX_AW_DEF = 11;
    localparam int PLANES_DEF = 3;

    // Horizontal-counter phases at which the timing generator raises the strobes.
    localparam logic [2:0] HN_FETCH = 3'b010;
    localparam logic [2:0] HN_LOAD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/obj_plane_shreg.sv
// rtl/obj_plane_shreg.sv - one 8-bit object bitplane shift register
// Purpose: loads a plane byte (optionally bit-reversed) and shifts it left one
//          pixel per ce with zero fill; the MSB is the current pixel bit.
// Ports:   i_clk, i_reset (sync, active-high), i_ce (pixel enable),
//          i_load (load instead of shift), i_flip (bit-reverse on load),
//          i_data (plane byte), o_msb (current pixel bit).
module obj_plane_shreg
    import taitosj_obj_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_load,
    input  logic       i_flip,
    input  logic [7:0] i_data,
    output logic       o_msb
);

    logic [7:0] r_sh;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh <= 8'h00;
        end else if (i_ce) begin
            if (i_load) begin
                r_sh <= i_flip ? bitrev8(i_data) : i_data;
            end else begin
                r_sh <= {r_sh[6:0], 1'b0};
            end
        end
    end

    assign o_msb = r_sh[7];

endmodule

// File: rtl/obj_pixel_shifter.sv
// rtl/obj_pixel_shifter.sv - object graphics fetch and pixel shifter
// Purpose: per 8-pixel object slice, fetches PLANES bitplanes from the shared
//          gfx RAM (req/ack) and shifts them out as the QBUS colour code, with
//          in-range gating and horizontal flip.
// Ports:   clkm_48MHZ, reset (sync, active-high), pix_ce, fetch_stb, load_stb,
//          OBJ_CHA, OBJ_CINV, INRANG, gfx_req/gfx_addr/gfx_ack/gfx_data (RAM
//          port), QBUS (pixel code), underrun_cnt (missed fetches).
// Config:  OBJ_UNDERRUN_CNT_EN builds the saturating underrun counter;
//          otherwise underrun_cnt is tied to zero.
module obj_pixel_shifter
    import taitosj_obj_pkg::*;
#(
    parameter int GFX_AW = GFX_AW_DEF,
    parameter int PLANES = PLANES_DEF
) (
    input  logic                  clkm_48MHZ,
    input  logic                  reset,
    input  logic                  pix_ce,
    input  logic                  fetch_stb,
    input  logic                  load_stb,
    input  logic [12:0]           OBJ_CHA,
    input  logic                  OBJ_CINV,
    input  logic                  INRANG,
    output logic                  gfx_req,
    output logic [GFX_AW-1:0]     gfx_addr,
    input  logic                  gfx_ack,
    input  logic [8*PLANES-1:0]   gfx_data,
    output logic [PLANES-1:0]     QBUS,
    output logic [7:0]            underrun_cnt
);

    fetch_state_t              r_state;
    logic                      r_gfx_req;
    logic [GFX_AW-1:0]         r_gfx_addr;
    logic                      r_flip_p;
    logic                      r_rng_p;
    logic [8*PLANES-1:0]       r_pending;
    logic                      r_rng_reg;
    logic [PLANES-1:0]         r_qbus;

    logic                      w_fetch;
    logic                      w_load;
    logic [8*PLANES-1:0]       w_load_data;
    logic [PLANES-1:0]         w_msb;
    logic                      w_unused_cha;

    assign w_fetch      = fetch_stb & pix_ce;
    assign w_load       = load_stb & pix_ce;
    assign w_unused_cha = &{1'b0, OBJ_CHA[12:GFX_AW]};

    // Data entering the shifter on a load: fetched data, same-cycle bypass of
    // a late ack, or zeros when nothing arrived in time.
    always_comb begin
        w_load_data = '0;
        if (r_state == READY) begin
            w_load_data = r_pending;
        end else if (r_state == REQ && gfx_ack) begin
            w_load_data = gfx_data;
        end
    end

    // Load is handled first; a fetch in the same cycle then overrides the
    // state, so it always restarts from IDLE. A fetch also wins over an ack
    // that arrives with it, because that ack belongs to the superseded slice.
    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gfx_req  <= 1'b0;
            r_gfx_addr <= '0;
            r_flip_p   <= 1'b0;
            r_rng_p    <= 1'b0;
            r_pending  <= '0;
        end else begin
            if (w_load) begin
                r_state   <= IDLE;
                r_gfx_req <= 1'b0;
            end
            if (w_fetch) begin
                r_state    <= REQ;
                r_gfx_req  <= 1'b1;
                r_gfx_addr <= OBJ_CHA[GFX_AW-1:0];
                r_flip_p   <= OBJ_CINV;
                r_rng_p    <= INRANG;
                r_pending  <= '0;
            end else if (!w_load && r_state == REQ && gfx_ack) begin
                r_state   <= READY;
                r_gfx_req <= 1'b0;
                r_pending <= gfx_data;
            end
        end
    end

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        obj_plane_shreg u_plane (
            .i_clk   (clkm_48MHZ),
            .i_reset (reset),
            .i_ce    (pix_ce),
            .i_load  (w_load),
            .i_flip  (r_flip_p),
            .i_data  (w_load_data[8*p +: 8]),
            .o_msb   (w_msb[p])
        );
    end

    // QBUS samples the shifter before it moves, so the first pixel of a slice
    // appears one pix_ce after its load.
    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            r_rng_reg <= 1'b0;
            r_qbus    <= '0;
        end else if (pix_ce) begin
            r_qbus <= r_rng_reg ? w_msb : '0;
            if (w_load) begin
                r_rng_reg <= r_rng_p;
            end
        end
    end

    assign gfx_req  = r_gfx_req;
    assign gfx_addr = r_gfx_addr;
    assign QBUS     = r_qbus;

`ifdef OBJ_UNDERRUN_CNT_EN
    logic       w_underrun;
    logic [7:0] r_underrun_cnt;

    // A load abort and a restarting fetch cannot both count in one cycle: a
    // fetch alongside a load starts from IDLE.
    assign w_underrun = (w_load && r_state == REQ && !gfx_ack) ||
                        (w_fetch && !w_load && r_state != IDLE);

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            r_underrun_cnt <= 8'h00;
        end else if (w_underrun && r_underrun_cnt != 8'hFF) begin
            r_underrun_cnt <= r_underrun_cnt + 8'h01;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_obj_pixel_shifter.sv
// tb/tb_obj_pixel_shifter.sv - self-checking bench for obj_pixel_shifter
module tb_obj_pixel_shifter;

    logic        clk;
    logic        rst;
    logic        pix_ce;
    logic        fetch_stb;
    logic        load_stb;
    logic [12:0] cha;
    logic        cinv;
    logic        inrang;
    logic        gfx_req;
    logic [10:0] gfx_addr;
    logic        gfx_ack;
    logic [23:0] gfx_data;
    logic [2:0]  qbus;
    logic [7:0]  ucnt;

    obj_pixel_shifter dut (
        .clkm_48MHZ   (clk),
        .reset        (rst),
        .pix_ce       (pix_ce),
        .fetch_stb    (fetch_stb),
        .load_stb     (load_stb),
        .OBJ_CHA      (cha),
        .OBJ_CINV     (cinv),
        .INRANG       (inrang),
        .gfx_req      (gfx_req),
        .gfx_addr     (gfx_addr),
        .gfx_ack      (gfx_ack),
        .gfx_data     (gfx_data),
        .QBUS         (qbus),
        .underrun_cnt (ucnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Stimulus intent for the next edge.
    bit          b_rst, b_pce, b_f, b_l, b_ack, b_cinv, b_inr;
    logic [12:0] b_cha;
    logic [23:0] b_data;

    // Slice-level reference model.
    int          pix_q[$];   // pixel codes still to be shown by the shifter
    int          sb[$];      // expected QBUS per pix_ce edge
    bit          m_req, m_have, m_flip, m_rng;
    logic [23:0] m_data;
    int          m_addr;
    int          m_under;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_under();
`ifdef OBJ_UNDERRUN_CNT_EN
        return m_under;
`else
        return 0;
`endif
    endfunction

    // Pixel i of a slice takes bit (7-i) of every plane, or bit i when flipped.
    function automatic int code_of(input logic [23:0] d, input int i, input bit flip, input bit rng);
        int bp;
        bp = flip ? i : 7 - i;
        if (!rng) return 0;
        return (int'(d[16+bp]) << 2) | (int'(d[8+bp]) << 1) | int'(d[bp]);
    endfunction

    task automatic bump_under();
        if (m_under < 255) m_under++;
    endtask

    task automatic model_step();
        bit          f, l;
        logic [23:0] src;
        if (b_rst) begin
            pix_q.delete();
            m_req = 0; m_have = 0; m_flip = 0; m_rng = 0; m_addr = 0; m_under = 0;
            m_data = '0;
            return;
        end
        f = b_pce & b_f;
        l = b_pce & b_l;
        if (b_pce) begin
            sb.push_back(pix_q.size() > 0 ? pix_q.pop_front() : 0);
        end
        if (l) begin
            if (m_have) src = m_data;
            else if (m_req && b_ack) src = b_data;
            else begin
                src = '0;
                if (m_req) bump_under();
            end
            pix_q.delete();
            for (int i = 0; i < 8; i++) pix_q.push_back(code_of(src, i, m_flip, m_rng));
            m_req = 0;
            m_have = 0;
        end
        if (f) begin
            if (!l && (m_req || m_have)) bump_under();
            m_addr = int'(b_cha[10:0]);
            m_flip = b_cinv;
            m_rng  = b_inr;
            m_req  = 1;
            m_have = 0;
        end else if (!l && m_req && b_ack) begin
            m_data = b_data;
            m_have = 1;
            m_req  = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rst = b_rst; pix_ce = b_pce; fetch_stb = b_f; load_stb = b_l;
        cha = b_cha; cinv = b_cinv; inrang = b_inr;
        gfx_ack = b_ack; gfx_data = b_data;
        model_step();
        @(posedge clk);
        #1;
        chk("gfx_req", gfx_req, m_req);
        if (m_req) chk("gfx_addr", gfx_addr, m_addr);
        chk("underrun_cnt", ucnt, exp_under());
    endtask

    // One pixel period: pix_ce on cycle 0 carrying the strobes, optional ack
    // on cycle ack_at, optional stray strobes/acks on the other cycles.
    task automatic slot(input bit f, input bit l, input int ack_at, input bit noise);
        for (int c = 0; c < 8; c++) begin
            b_pce = (c == 0);
            b_f   = (c == 0) ? f : (noise && ($urandom % 2 == 1));
            b_l   = (c == 0) ? l : (noise && ($urandom % 2 == 1));
            b_ack = (c == ack_at) || (noise && ($urandom % 8 == 0));
            tick();
        end
        b_pce = 0; b_f = 0; b_l = 0; b_ack = 0;
    endtask

    task automatic idle_slots(input int n);
        for (int k = 0; k < n; k++) slot(0, 0, -1, 0);
    endtask

    // Scoreboard monitor: every pix_ce edge produces one QBUS value.
    always @(posedge clk) begin
        if (pix_ce && !rst) begin
            #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL qbus_unexpected: got %0d expected none", qbus);
            end else begin
                chk("qbus", qbus, sb.pop_front());
            end
        end
    end

    initial begin
        b_rst = 1; b_pce = 0; b_f = 0; b_l = 0; b_ack = 0;
        b_cha = '0; b_cinv = 0; b_inr = 1; b_data = '0;
        tick();
        tick();
        chk("reset_qbus", qbus, 0);
        chk("reset_addr", gfx_addr, 0);
        b_rst = 0;
        idle_slots(2);

        // Ack three cycles after the request, plain orientation.
        b_cha = 13'h0456; b_data = 24'hF0_0F_AA; b_cinv = 0; b_inr = 1;
        slot(1, 0, 3, 0);
        slot(0, 1, -1, 0);
        idle_slots(10);

        // Flipped, then out of range.
        b_cinv = 1;
        slot(1, 0, 3, 0);
        slot(0, 1, -1, 0);
        idle_slots(9);
        b_cinv = 0; b_inr = 0;
        slot(1, 0, 3, 0);
        slot(0, 1, -1, 0);
        idle_slots(9);
        b_inr = 1;

        // No ack before load: abort.
        slot(1, 0, -1, 0);
        slot(0, 1, -1, 0);
        chk("abort_req_low", gfx_req, 0);
        idle_slots(9);

        // Ack together with load: bypass.
        b_data = 24'hFF_FF_FF;
        slot(1, 0, -1, 0);
        slot(0, 1, 0, 0);
        idle_slots(10);

        // Refetch while a slice is pending: newest slice wins.
        b_cha = 13'h0456; b_data = 24'h12_34_56;
        slot(1, 0, 2, 0);
        b_cha = 13'h0123;
        slot(1, 0, -1, 0);
        chk("refetch_addr", gfx_addr, 11'h123);
        b_data = 24'hC3_5A_81;
        slot(0, 0, 4, 0);
        slot(0, 1, -1, 0);
        idle_slots(9);

        // Reset while requesting; a late ack must be ignored.
        slot(1, 0, -1, 0);
        b_rst = 1;
        tick();
        b_rst = 0;
        chk("rst_mid_qbus", qbus, 0);
        b_ack = 1;
        tick();
        b_ack = 0;
        chk("late_ack_req", gfx_req, 0);
        slot(0, 1, -1, 0);
        idle_slots(9);

        // 300 back-to-back refetches.
        for (int k = 0; k < 300; k++) slot(1, 0, -1, 0);
`ifdef OBJ_UNDERRUN_CNT_EN
        chk("underrun_sat", ucnt, 255);
`else
        chk("underrun_off", ucnt, 0);
`endif
        slot(0, 1, -1, 0);
        idle_slots(9);

        // Randomised traffic including stray strobes and acks.
        for (int k = 0; k < 1200; k++) begin
            b_cha  = 13'($urandom);
            b_cinv = ($urandom % 2 == 1);
            b_inr  = ($urandom % 4 != 0);
            b_data = 24'($urandom);
            slot(($urandom % 2 == 1), ($urandom % 3 == 0), int'($urandom_range(0, 8)) - 1, 1);
        end
        idle_slots(10);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
